// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decryption key path.
// Round keys are MSB-first: bit 0 is the top bit of byte 0.
package aes_dec_pkg;

    typedef logic [0:127] rkey_t;

    localparam int AES128_NR = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        PLAY  = 2'd3
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_columns_word.sv
// Combinational InvMixColumns on one 32-bit column, byte 0 in col[31:24].
module inv_mix_columns_word
    import aes_dec_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] res
);

    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            m9[i]  = xtime(xtime(xtime(a[i]))) ^ a[i];
            m11[i] = m9[i] ^ xtime(a[i]);
            m13[i] = m9[i] ^ xtime(xtime(a[i]));
            m14[i] = xtime(xtime(xtime(a[i]))) ^ xtime(xtime(a[i])) ^ xtime(a[i]);
        end
    end

    // Row r uses the circulant {14,11,13,9} rotated right by r
    always_comb begin
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
        end
    end

endmodule

// File: rtl/rkey_reverse_buf.sv
// Captures forward round keys from the expander and replays them in reverse
// order to the decrypt datapath, optionally in equivalent-inverse-cipher form.
module rkey_reverse_buf
    import aes_dec_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter bit EQ_INV = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  rkey_t rkey_in,
    input  logic  rkey_in_vld,
    input  logic  rkey_in_last,
    output logic  ld_rdy,
    output logic  ld_err,
    output logic  keys_valid,
    input  logic  rd_start,
    output logic  rd_rdy,
    output rkey_t rk_out,
    output logic  rk_out_vld,
    output logic  rk_out_first,
    output logic  rk_out_last
);

    localparam int CW = $clog2(NR + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NR);

    state_e        state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_ptr;
    logic          pend;
    rkey_t         keys [0:NR];

    rkey_t         imc_key;
    rkey_t         wr_data;
    logic [CW-1:0] wr_idx;
    logic          wr_en;

    generate
        if (EQ_INV) begin : g_imc
            for (genvar c = 0; c < 4; c++) begin : g_col
                inv_mix_columns_word u_imc (
                    .col (rkey_in[32*c +: 32]),
                    .res (imc_key[32*c +: 32])
                );
            end
        end else begin : g_raw
            assign imc_key = rkey_in;
        end
    endgenerate

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (!flush && rkey_in_vld) begin
            case (state)
                EMPTY:   wr_en = 1'b1;
                LOAD: begin
                    wr_en  = 1'b1;
                    wr_idx = wr_cnt;
                end
                FULL:    wr_en = !rd_start && !pend;
                default: wr_en = 1'b0;
            endcase
        end
        // First and last round keys are used raw even in the equivalent cipher
        wr_data = (EQ_INV && wr_idx != '0 && wr_idx != LAST_IDX) ? imc_key : rkey_in;
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_idx <= LAST_IDX)
            keys[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EMPTY;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            pend         <= 1'b0;
            ld_rdy       <= 1'b1;
            ld_err       <= 1'b0;
            keys_valid   <= 1'b0;
            rd_rdy       <= 1'b0;
            rk_out       <= '0;
            rk_out_vld   <= 1'b0;
            rk_out_first <= 1'b0;
            rk_out_last  <= 1'b0;
        end else begin
            ld_err       <= 1'b0;
            rk_out_vld   <= 1'b0;
            rk_out_first <= 1'b0;
            rk_out_last  <= 1'b0;
            if (flush) begin
                state      <= EMPTY;
                wr_cnt     <= '0;
                rd_ptr     <= '0;
                pend       <= 1'b0;
                ld_rdy     <= 1'b1;
                keys_valid <= 1'b0;
                rd_rdy     <= 1'b0;
                rk_out     <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (rkey_in_vld) begin
                            if (rkey_in_last) begin
                                ld_err <= 1'b1;
                            end else begin
                                state  <= LOAD;
                                wr_cnt <= CW'(1);
                                ld_rdy <= 1'b0;
                            end
                        end
                    end
                    LOAD: begin
                        if (!rkey_in_vld || (rkey_in_last != (wr_cnt == LAST_IDX))) begin
                            ld_err <= 1'b1;
                            state  <= EMPTY;
                            wr_cnt <= '0;
                            ld_rdy <= 1'b1;
                        end else if (rkey_in_last) begin
                            state      <= FULL;
                            wr_cnt     <= '0;
                            keys_valid <= 1'b1;
                            ld_rdy     <= 1'b1;
                            rd_rdy     <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                    FULL: begin
                        if (rd_start || pend) begin
                            pend         <= 1'b0;
                            state        <= PLAY;
                            rk_out       <= keys[LAST_IDX];
                            rk_out_vld   <= 1'b1;
                            rk_out_first <= 1'b1;
                            rd_ptr       <= LAST_IDX - 1'b1;
                            ld_rdy       <= 1'b0;
                            rd_rdy       <= 1'b0;
                        end else if (rkey_in_vld) begin
                            keys_valid <= 1'b0;
                            rd_rdy     <= 1'b0;
                            if (rkey_in_last) begin
                                ld_err <= 1'b1;
                                state  <= EMPTY;
                            end else begin
                                state  <= LOAD;
                                wr_cnt <= CW'(1);
                                ld_rdy <= 1'b0;
                            end
                        end
                    end
                    PLAY: begin
                        // The cycle showing round 0 is the mandatory idle slot; a start
                        // taken here is parked and launched from FULL next cycle.
                        if (rk_out_last) begin
                            state <= FULL;
                            if (rd_start) begin
                                pend   <= 1'b1;
                                rd_rdy <= 1'b0;
                            end else begin
                                ld_rdy <= 1'b1;
                            end
                        end else begin
                            rk_out     <= keys[rd_ptr];
                            rk_out_vld <= 1'b1;
                            if (rd_ptr == '0) begin
                                rk_out_last <= 1'b1;
                                rd_rdy      <= 1'b1;
                            end else begin
                                rd_ptr <= rd_ptr - 1'b1;
                            end
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rkey_reverse_buf.sv
// Scoreboard bench: two instances (raw and equivalent-inverse keys) share
// stimulus; a monitor pops expected keys whenever rk_out_vld is high.
module tb_rkey_reverse_buf;

    localparam int NR = 10;

    localparam logic [127:0] FIPS [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};

    localparam int IMC_M [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13},
                                    '{13, 9, 14, 11}, '{11, 13, 9, 14}};

    typedef struct {
        logic [127:0] key;
        logic         first;
        logic         last;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         rkey_in_vld = 1'b0;
    logic         rkey_in_last = 1'b0;
    logic         rd_start = 1'b0;
    logic [127:0] rkey_in = '0;
    logic [1:0]   ld_rdy, ld_err, keys_valid, rd_rdy, vld, first, last;
    logic [127:0] rk_out [2];

    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    exp_t         sb0 [$];
    exp_t         sb1 [$];
    logic [127:0] cur [0:NR];
    logic [127:0] ref_keys [0:NR];

    rkey_reverse_buf #(.NR(NR), .EQ_INV(1'b0)) u_raw (
        .clk(clk), .rst(rst), .flush(flush), .rkey_in(rkey_in),
        .rkey_in_vld(rkey_in_vld), .rkey_in_last(rkey_in_last),
        .ld_rdy(ld_rdy[0]), .ld_err(ld_err[0]), .keys_valid(keys_valid[0]),
        .rd_start(rd_start), .rd_rdy(rd_rdy[0]), .rk_out(rk_out[0]),
        .rk_out_vld(vld[0]), .rk_out_first(first[0]), .rk_out_last(last[0]));

    rkey_reverse_buf #(.NR(NR), .EQ_INV(1'b1)) u_eqv (
        .clk(clk), .rst(rst), .flush(flush), .rkey_in(rkey_in),
        .rkey_in_vld(rkey_in_vld), .rkey_in_last(rkey_in_last),
        .ld_rdy(ld_rdy[1]), .ld_err(ld_err[1]), .keys_valid(keys_valid[1]),
        .rd_start(rd_start), .rd_rdy(rd_rdy[1]), .rk_out(rk_out[1]),
        .rk_out_vld(vld[1]), .rk_out_first(first[1]), .rk_out_last(last[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] k);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(k[127-8*(4*c+j) -: 8], IMC_M[r][j]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input int ldr, input int err, input int kv,
                          input int rr, input int v);
        for (int d = 0; d < 2; d++) begin
            chkb($sformatf("%s_ld_rdy%0d", tag, d), int'(ld_rdy[d]), ldr);
            chkb($sformatf("%s_ld_err%0d", tag, d), int'(ld_err[d]), err);
            chkb($sformatf("%s_keys_valid%0d", tag, d), int'(keys_valid[d]), kv);
            chkb($sformatf("%s_rd_rdy%0d", tag, d), int'(rd_rdy[d]), rr);
            chkb($sformatf("%s_vld%0d", tag, d), int'(vld[d]), v);
        end
    endtask

    // Reverse-order expectation: raw keys for one instance, equivalent-cipher
    // keys (InvMixColumns on inner rounds) for the other.
    task automatic push_exp(input int base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int r = NR - i;
            e.key   = ref_keys[r];
            e.first = (i == 0);
            e.last  = (i == NR);
            e.cyc   = base + i;
            sb0.push_back(e);
            e.key = (r == 0 || r == NR) ? ref_keys[r] : imc(ref_keys[r]);
            sb1.push_back(e);
        end
    endtask

    task automatic load_full();
        for (int i = 0; i <= NR; i++) begin
            rkey_in      = cur[i];
            rkey_in_vld  = 1'b1;
            rkey_in_last = (i == NR);
            tick();
        end
        rkey_in_vld  = 1'b0;
        rkey_in_last = 1'b0;
        for (int i = 0; i <= NR; i++) ref_keys[i] = cur[i];
        status("loaded", 1, 0, 1, 1, 0);
    endtask

    task automatic play_now();
        rd_start = 1'b1;
        push_exp(cyc + 1, NR + 1);
        tick();
        rd_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb0.size() + sb1.size()) != 0; i++) tick();
        chkb("drain_empty", sb0.size() + sb1.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d]) begin
                    if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out%0d cyc=%0d act=%h exp=none", d, cyc, rk_out[d]);
                    end else begin
                        if (d == 0) e = sb0.pop_front();
                        else        e = sb1.pop_front();
                        chk($sformatf("rk_out%0d", d), rk_out[d], e.key);
                        chkb($sformatf("first%0d", d), int'(first[d]), int'(e.first));
                        chkb($sformatf("last%0d", d), int'(last[d]), int'(e.last));
                        chkb($sformatf("out_cycle%0d", d), cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        #1 rst = 1'b0;
        repeat (3) tick();
        status("reset", 1, 0, 0, 0, 0);
        chk("reset_rk_out0", rk_out[0], '0);
        chk("reset_rk_out1", rk_out[1], '0);
        rst = 1'b1;
        tick();

        // FIPS-197 key, single playback
        for (int i = 0; i <= NR; i++) cur[i] = FIPS[i];
        load_full();
        play_now();
        drain();

        // Three back-to-back bursts, each restarted on the round-0 cycle
        target = cyc + NR + 1;
        play_now();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 40 && cyc < target; i++) tick();
            chkb("b2b_last_seen", int'(last[0]), 1);
            chkb("b2b_rd_rdy", int'(rd_rdy[0]), 1);
            rd_start = 1'b1;
            push_exp(cyc + 2, NR + 1);
            target = cyc + 2 + NR;
            tick();
            rd_start = 1'b0;
        end
        drain();

        // rd_start and rkey_in_vld together in FULL: playback of the held keys
        rd_start    = 1'b1;
        rkey_in_vld = 1'b1;
        rkey_in     = rand128();
        push_exp(cyc + 1, NR + 1);
        tick();
        rd_start    = 1'b0;
        rkey_in_vld = 1'b0;
        drain();

        // Truncated load: valid drops after 5 keys
        for (int i = 0; i < 5; i++) begin
            rkey_in = rand128();
            rkey_in_vld = 1'b1;
            tick();
        end
        rkey_in_vld = 1'b0;
        tick();
        status("trunc", 1, 1, 0, 0, 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        status("trunc_rd", 1, 0, 0, 0, 0);
        tick();
        status("trunc_idle", 1, 0, 0, 0, 0);

        // Last flag on the very first key
        rkey_in_vld  = 1'b1;
        rkey_in_last = 1'b1;
        tick();
        rkey_in_vld  = 1'b0;
        rkey_in_last = 1'b0;
        status("early_last", 1, 1, 0, 0, 0);

        // Flush during the 4th playback cycle
        for (int i = 0; i <= NR; i++) cur[i] = FIPS[i];
        load_full();
        rd_start = 1'b1;
        push_exp(cyc + 1, 4);
        tick();
        rd_start = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        status("flush", 1, 0, 0, 0, 0);
        chkb("flush_q_empty", sb0.size() + sb1.size(), 0);

        // Reload in FULL with a second key, then play
        load_full();
        cur[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int i = 1; i < NR; i++) cur[i] = rand128();
        cur[NR] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        load_full();
        play_now();
        drain();

        // Random key sets with random idle gaps
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i <= NR; i++) cur[i] = rand128();
            load_full();
            repeat ($urandom_range(0, 3)) tick();
            play_now();
            drain();
        end

        // Asynchronous reset in the middle of a load
        for (int i = 0; i < 4; i++) begin
            rkey_in = rand128();
            rkey_in_vld = 1'b1;
            tick();
        end
        #2 rst = 1'b0;
        #1;
        status("rst_mid", 1, 0, 0, 0, 0);
        chk("rst_mid_rk_out0", rk_out[0], '0);
        chk("rst_mid_rk_out1", rk_out[1], '0);
        rkey_in_vld = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        status("post_rst", 1, 0, 0, 0, 0);

        for (int i = 0; i <= NR; i++) cur[i] = rand128();
        load_full();
        play_now();
        drain();

        repeat (2) tick();
        chkb("final_q_empty", sb0.size() + sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
